// File: rtl/pim_pkg.sv
// Shared sizing and state encoding for the PIM dot-product engine.
package pim_pkg;
  localparam int LANES          = 32;
  localparam int LANE_W         = 16;
  localparam int LANES_PER_BEAT = 2;
  localparam int ACC_W          = 64;
  localparam int ROW_W          = LANES * LANE_W;
  localparam int PAIR_W         = LANES_PER_BEAT * LANE_W;
  localparam int BEATS          = LANES / LANES_PER_BEAT;
  localparam int BEAT_W         = $clog2(BEATS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_REARM = 2'd2
  } pim_state_t;
endpackage

// File: rtl/pim_mac_pair.sv
// Combinational signed multiply of LANES_PER_BEAT lane pairs, summed and
// sign-extended to the accumulator width.
module pim_mac_pair
  import pim_pkg::*;
(
  input  logic [PAIR_W-1:0] a,
  input  logic [PAIR_W-1:0] b,
  output logic [ACC_W-1:0]  sum
);
  logic [LANES_PER_BEAT-1:0][2*LANE_W-1:0] prod;

  for (genvar i = 0; i < LANES_PER_BEAT; i++) begin : g_lane
    logic signed [LANE_W-1:0]   la, lb;
    logic signed [2*LANE_W-1:0] p;
    assign la = a[i*LANE_W +: LANE_W];
    assign lb = b[i*LANE_W +: LANE_W];
    // widen before multiplying so the full 32-bit signed product is kept
    assign p  = (2*LANE_W)'(la) * (2*LANE_W)'(lb);
    assign prod[i] = p;
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES_PER_BEAT; i++)
      sum = sum + {{(ACC_W-2*LANE_W){prod[i][2*LANE_W-1]}}, prod[i]};
  end
endmodule

// File: rtl/pim_dot_engine.sv
// Serial signed dot product of two 32x16-bit rows, 2 lanes per beat.
// Optional PIM_EARLY_EXIT_EN finishes once the remaining op_a lanes are zero.
module pim_dot_engine
  import pim_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             pim_start,
  input  logic [ROW_W-1:0] op_a,
  input  logic [ROW_W-1:0] op_b,
  output logic             pim_done,
  output logic [ACC_W-1:0] pim_result,
  output logic             pim_busy,
  output logic [31:0]      op_count,
  output logic [31:0]      busy_cycles
);
  pim_state_t       state;
  logic [ROW_W-1:0] sh_a, sh_b, sh_a_nxt, sh_b_nxt;
  logic [BEAT_W-1:0] beat;
  logic [ACC_W-1:0] acc, pair_sum, acc_nxt;
  logic             last_beat;

  pim_mac_pair u_mac (
    .a  (sh_a[PAIR_W-1:0]),
    .b  (sh_b[PAIR_W-1:0]),
    .sum(pair_sum)
  );

  assign acc_nxt  = acc + pair_sum;
  assign sh_a_nxt = sh_a >> PAIR_W;
  assign sh_b_nxt = sh_b >> PAIR_W;

`ifdef PIM_EARLY_EXIT_EN
  // nothing left to add once every remaining A lane is zero
  assign last_beat = (beat == BEAT_W'(BEATS-1)) || (sh_a_nxt == '0);
`else
  assign last_beat = (beat == BEAT_W'(BEATS-1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      sh_a        <= '0;
      sh_b        <= '0;
      acc         <= '0;
      beat        <= '0;
      pim_done    <= 1'b0;
      pim_result  <= '0;
      pim_busy    <= 1'b0;
      op_count    <= '0;
      busy_cycles <= '0;
    end else begin
      pim_done <= 1'b0;
      case (state)
        ST_IDLE: if (pim_start) begin
          sh_a     <= op_a;
          sh_b     <= op_b;
          acc      <= '0;
          beat     <= '0;
          op_count <= op_count + 32'd1;
          pim_busy <= 1'b1;
          state    <= ST_RUN;
        end
        ST_RUN: begin
          acc         <= acc_nxt;
          sh_a        <= sh_a_nxt;
          sh_b        <= sh_b_nxt;
          beat        <= beat + 1'b1;
          busy_cycles <= busy_cycles + 32'd1;
          if (last_beat) begin
            pim_result <= acc_nxt;
            pim_done   <= 1'b1;
            pim_busy   <= 1'b0;
            state      <= ST_REARM;
          end
        end
        // wait for start to drop so a held or trailing start cannot re-trigger
        ST_REARM: if (!pim_start) state <= ST_IDLE;
        default: begin
          pim_busy <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pim_dot_engine.sv
// Randomized self-checking bench for pim_dot_engine against a lane-level model.
module tb_pim_dot_engine;
  localparam int LANES = 32;
  localparam int ROW_W = 512;

  logic             clk = 1'b0;
  logic             rst;
  logic             pim_start;
  logic [ROW_W-1:0] op_a, op_b;
  logic             pim_done;
  logic [63:0]      pim_result;
  logic             pim_busy;
  logic [31:0]      op_count, busy_cycles;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_ops = '0;
  logic [31:0] exp_busy = '0;

  always #5 clk = ~clk;

  pim_dot_engine dut (
    .clk        (clk),
    .rst        (rst),
    .pim_start  (pim_start),
    .op_a       (op_a),
    .op_b       (op_b),
    .pim_done   (pim_done),
    .pim_result (pim_result),
    .pim_busy   (pim_busy),
    .op_count   (op_count),
    .busy_cycles(busy_cycles)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h want 0x%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] dot(input logic [ROW_W-1:0] a, input logic [ROW_W-1:0] b);
    longint s = 0;
    shortint x, y;
    for (int i = 0; i < LANES; i++) begin
      x = a[i*16 +: 16];
      y = b[i*16 +: 16];
      s += longint'(x) * longint'(y);
    end
    return s;
  endfunction

  // cycles from the accepting edge's following negedge to done, per the rules
  function automatic int exp_latency(input logic [ROW_W-1:0] a);
`ifdef PIM_EARLY_EXIT_EN
    int last = 0;
    for (int p = 0; p < LANES/2; p++)
      if (a[p*32 +: 32] != 32'd0) last = p;
    return last + 2;
`else
    return 17;
`endif
  endfunction

  function automatic logic [ROW_W-1:0] fill(input logic [15:0] v);
    logic [ROW_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*16 +: 16] = v;
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] rnd_row(input bit trim);
    logic [ROW_W-1:0] r;
    int k;
    for (int i = 0; i < LANES; i++) r[i*16 +: 16] = 16'($urandom);
    if (trim) begin
      k = $urandom_range(0, LANES-1);
      for (int i = 0; i < LANES; i++) if (i >= k) r[i*16 +: 16] = 16'd0;
    end
    return r;
  endfunction

  // one controller-style op: raise start, wait for done, hold start, then drop
  task automatic run_op(input string tag, input logic [ROW_W-1:0] a,
                        input logic [ROW_W-1:0] b, input int hold, input bit scramble);
    int  lat = 0;
    bit  seen = 0;
    int  want = exp_latency(a);
    logic [63:0] res = dot(a, b);
    @(negedge clk);
    op_a = a; op_b = b; pim_start = 1'b1;
    while (lat < 40 && !seen) begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk({tag, "_busy"}, 64'(pim_busy), 64'd1);
      if (scramble && lat == 4) begin op_a = ~op_a; op_b = rnd_row(0); end
      if (pim_done) seen = 1;
    end
    exp_ops++;
    exp_busy += 32'(want - 1);
    chk({tag, "_done"}, 64'(seen), 64'd1);
    chk({tag, "_lat"}, 64'(lat), 64'(want));
    chk({tag, "_res"}, pim_result, res);
    chk({tag, "_ops"}, 64'(op_count), 64'(exp_ops));
    chk({tag, "_bcyc"}, 64'(busy_cycles), 64'(exp_busy));
    seen = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (pim_done || pim_busy) seen = 1;
    end
    pim_start = 1'b0;
    @(negedge clk);
    if (pim_done || pim_busy) seen = 1;
    chk({tag, "_single"}, 64'(seen), 64'd0);
    chk({tag, "_hold"}, pim_result, res);
    chk({tag, "_ops2"}, 64'(op_count), 64'(exp_ops));
  endtask

  initial begin
    logic [ROW_W-1:0] a, b;
    bit seen;
    rst = 1'b1; pim_start = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_done", 64'(pim_done), 64'd0);
    chk("rst_res", pim_result, 64'd0);
    chk("rst_busy", 64'(pim_busy), 64'd0);
    chk("rst_ops", 64'(op_count), 64'd0);
    chk("rst_bcyc", 64'(busy_cycles), 64'd0);

    run_op("ones", fill(16'h0001), fill(16'h0002), 1, 0);
    a = '0; a[15:0] = 16'hFFFD;
    b = '0; b[15:0] = 16'h0005;
    run_op("neg", a, b, 1, 0);
    run_op("max", fill(16'h8000), fill(16'h8000), 1, 0);
    run_op("hold", rnd_row(0), rnd_row(0), 24, 0);
    run_op("rearm", rnd_row(0), rnd_row(0), 1, 0);
    run_op("chg", rnd_row(0), rnd_row(0), 1, 1);
    run_op("zero", '0, rnd_row(0), 1, 0);
    for (int t = 0; t < 8; t++)
      run_op($sformatf("rnd%0d", t), rnd_row(t[0]), rnd_row(0), $urandom_range(1, 3), 0);

    // reset while beat 8 is executing
    @(negedge clk);
    op_a = fill(16'h1234); op_b = fill(16'h0101); pim_start = 1'b1;
    repeat (9) @(negedge clk);
    rst = 1'b1; pim_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_ops = '0; exp_busy = '0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pim_done) seen = 1;
    end
    chk("mid_rst_nodone", 64'(seen), 64'd0);
    chk("mid_rst_res", pim_result, 64'd0);
    chk("mid_rst_busy", 64'(pim_busy), 64'd0);
    chk("mid_rst_ops", 64'(op_count), 64'd0);
    chk("mid_rst_bcyc", 64'(busy_cycles), 64'd0);
    run_op("post_rst", fill(16'h7FFF), fill(16'hFFFF), 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
